// File: rtl/mem_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_rr_arbiter_if
// Bundles the consumer-side request/response bus and the shared memory
// channel of the round-robin memory arbiter.
//
// Signals
//   consumer_read_valid/address   consumer -> arbiter, read request
//   consumer_read_ready/data      arbiter -> consumer, read completion
//   consumer_write_valid/address/data   consumer -> arbiter, write request
//   consumer_write_ready          arbiter -> consumer, write ack
//   mem_read_valid/address        arbiter -> memory, read request
//   mem_read_ready/data           memory -> arbiter, read completion
//   mem_write_valid/address/data  arbiter -> memory, write request
//   mem_write_ready               memory -> arbiter, write ack
//
// Modports
//   master : the arbiter (drives the memory channel and consumer responses)
//   slave  : the surrounding consumers and memory
// ---------------------------------------------------------------------------
interface mem_rr_arbiter_if #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4
);
    logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    logic                 mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;

    modport master (
        input  consumer_read_valid, consumer_read_address,
        output consumer_read_ready, consumer_read_data,
        input  consumer_write_valid, consumer_write_address, consumer_write_data,
        output consumer_write_ready,
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );

    modport slave (
        output consumer_read_valid, consumer_read_address,
        input  consumer_read_ready, consumer_read_data,
        output consumer_write_valid, consumer_write_address, consumer_write_data,
        input  consumer_write_ready,
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mem_rr_arbiter
// Round-robin arbiter sharing one memory channel between NUM_CONSUMERS
// fetchers/LSUs. One transaction at a time: grant -> wait for memory ->
// relay the completion to the consumer -> back to idle.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low (0 = reset)
//   bus          mem_rr_arbiter_if.master: consumer and memory handshakes
//   grant_id     consumer owning (or last owning) the channel
//   busy         1 whenever the FSM is not idle
//   timeout_err  sticky watchdog flag
//
// Build option
//   MEM_ARB_TIMEOUT_EN : when defined, a wait counter aborts a memory access
//   after TIMEOUT_CYCLES cycles without ready, completes it to the consumer
//   (read data 0 / write ack) and sets timeout_err. When undefined the
//   arbiter waits indefinitely and timeout_err stays 0.
// ---------------------------------------------------------------------------
module mem_rr_arbiter #(
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 16,
    parameter int NUM_CONSUMERS  = 4,
    parameter int WRITE_ENABLE   = 1,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int CW            = $clog2(NUM_CONSUMERS)
) (
    input  logic          clk,
    input  logic          reset,
    mem_rr_arbiter_if.master bus,
    output logic [CW-1:0] grant_id,
    output logic          busy,
    output logic          timeout_err
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RELAY} state_t;

    localparam logic          WR_EN = (WRITE_ENABLE != 0);
    localparam logic [CW:0]   N_W   = (CW+1)'(NUM_CONSUMERS);

    state_t                                  state_reg;
    logic [CW-1:0]                           grant_reg;
    logic [CW-1:0]                           last_grant_reg;
    logic                                    op_write_reg;
    logic                                    mem_read_valid_reg;
    logic                                    mem_write_valid_reg;
    logic [ADDR_BITS-1:0]                    mem_read_address_reg;
    logic [ADDR_BITS-1:0]                    mem_write_address_reg;
    logic [DATA_BITS-1:0]                    mem_write_data_reg;
    logic [NUM_CONSUMERS-1:0]                read_ready_reg;
    logic [NUM_CONSUMERS-1:0]                write_ready_reg;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] read_data_reg;
    logic                                    timeout_err_reg;

    // Per-consumer request: writes count only on builds with a write port.
    logic [NUM_CONSUMERS-1:0] req;
    for (genvar gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_req
        assign req[gi] = bus.consumer_read_valid[gi] | (WR_EN & bus.consumer_write_valid[gi]);
    end

    // Priority rotate: shift a doubled request vector so bit 0 corresponds to
    // last_grant+1, find the lowest set bit, then map the offset back to an id.
    logic [CW:0]                start;
    logic [2*NUM_CONSUMERS-1:0] req_shift;
    logic [NUM_CONSUMERS-1:0]   rot;
    logic [CW-1:0]              offset;
    logic [CW:0]                sum;
    logic [CW-1:0]              winner;
    logic                       any_req;

    assign start     = {1'b0, last_grant_reg} + (CW+1)'(1);
    assign req_shift = {req, req} >> start;
    assign rot       = req_shift[NUM_CONSUMERS-1:0];
    assign any_req   = |req;

    always_comb begin
        offset = '0;
        for (int j = NUM_CONSUMERS - 1; j >= 0; j--) begin
            if (rot[j]) begin
                offset = CW'(j);
            end
        end
    end

    assign sum    = start + {1'b0, offset};
    assign winner = (sum >= N_W) ? CW'(sum - N_W) : CW'(sum);

    // In RELAY the arbiter waits for the valid matching the operation it served.
    logic relay_valid;
    assign relay_valid = op_write_reg ? bus.consumer_write_valid[grant_reg]
                                      : bus.consumer_read_valid[grant_reg];

    logic wait_expired;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WCW = ($clog2(TIMEOUT_CYCLES) + 1 > 8) ? $clog2(TIMEOUT_CYCLES) + 1 : 8;
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(TIMEOUT_CYCLES - 1);

    logic [WCW-1:0] wait_cnt_reg;

    // Zero outside the wait states, so it is always 0 on entry to a wait.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_reg <= '0;
        end else if ((state_reg == RD_WAIT && !bus.mem_read_ready) ||
                     (state_reg == WR_WAIT && !bus.mem_write_ready)) begin
            wait_cnt_reg <= wait_cnt_reg + WCW'(1);
        end else begin
            wait_cnt_reg <= '0;
        end
    end

    assign wait_expired = (wait_cnt_reg == WAIT_LIMIT);
`else
    assign wait_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg             <= IDLE;
            grant_reg             <= '0;
            last_grant_reg        <= CW'(NUM_CONSUMERS - 1);
            op_write_reg          <= 1'b0;
            mem_read_valid_reg    <= 1'b0;
            mem_write_valid_reg   <= 1'b0;
            mem_read_address_reg  <= '0;
            mem_write_address_reg <= '0;
            mem_write_data_reg    <= '0;
            read_ready_reg        <= '0;
            write_ready_reg       <= '0;
            read_data_reg         <= '0;
            timeout_err_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        grant_reg      <= winner;
                        last_grant_reg <= winner;
                        // Read wins over write for the same consumer.
                        if (bus.consumer_read_valid[winner]) begin
                            op_write_reg         <= 1'b0;
                            mem_read_valid_reg   <= 1'b1;
                            mem_read_address_reg <= bus.consumer_read_address[winner];
                            state_reg            <= RD_WAIT;
                        end else begin
                            op_write_reg          <= 1'b1;
                            mem_write_valid_reg   <= 1'b1;
                            mem_write_address_reg <= bus.consumer_write_address[winner];
                            mem_write_data_reg    <= bus.consumer_write_data[winner];
                            state_reg             <= WR_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (bus.mem_read_ready) begin
                        mem_read_valid_reg        <= 1'b0;
                        read_data_reg[grant_reg]  <= bus.mem_read_data;
                        read_ready_reg[grant_reg] <= 1'b1;
                        state_reg                 <= RELAY;
                    end else if (wait_expired) begin
                        mem_read_valid_reg        <= 1'b0;
                        read_data_reg[grant_reg]  <= '0;
                        read_ready_reg[grant_reg] <= 1'b1;
                        timeout_err_reg           <= 1'b1;
                        state_reg                 <= RELAY;
                    end
                end
                WR_WAIT: begin
                    if (bus.mem_write_ready || wait_expired) begin
                        mem_write_valid_reg        <= 1'b0;
                        write_ready_reg[grant_reg] <= 1'b1;
                        if (!bus.mem_write_ready) begin
                            timeout_err_reg <= 1'b1;
                        end
                        state_reg <= RELAY;
                    end
                end
                RELAY: begin
                    if (!relay_valid) begin
                        read_ready_reg  <= '0;
                        write_ready_reg <= '0;
                        state_reg       <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.consumer_read_ready  = read_ready_reg;
    assign bus.consumer_read_data   = read_data_reg;
    assign bus.consumer_write_ready = write_ready_reg;
    assign bus.mem_read_valid       = mem_read_valid_reg;
    assign bus.mem_read_address     = mem_read_address_reg;
    assign bus.mem_write_valid      = mem_write_valid_reg;
    assign bus.mem_write_address    = mem_write_address_reg;
    assign bus.mem_write_data       = mem_write_data_reg;
    assign grant_id                 = grant_reg;
    assign busy                     = (state_reg != IDLE);
    assign timeout_err              = timeout_err_reg;
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_rr_arbiter
// Directed bench for mem_rr_arbiter: a read/write-capable instance with a
// behavioural memory responder and auto-releasing consumers, plus a
// WRITE_ENABLE=0 instance driven by hand. Prints one line per transaction.
// ---------------------------------------------------------------------------
module tb_mem_rr_arbiter;
    localparam int N  = 4;
    localparam int AB = 8;
    localparam int DB = 16;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_rr_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(N)) bus ();
    mem_rr_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(N)) bus2 ();

    logic [CW-1:0] grant_id, grant_id2;
    logic          busy, busy2, timeout_err, timeout_err2;

    mem_rr_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(N),
                     .WRITE_ENABLE(1), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    mem_rr_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(N),
                     .WRITE_ENABLE(0), .TIMEOUT_CYCLES(8)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2),
        .grant_id(grant_id2), .busy(busy2), .timeout_err(timeout_err2)
    );

    int total = 0;
    int passed = 0;
    int viol = 0;
    int rd_starts = 0;
    int wr2_seen = 0;
    int rd_latency = 1;
    bit mem_on = 1'b1;
    bit auto_release = 1'b0;
    bit prev_rv = 1'b0;
    int log_q[$];
    logic [DB-1:0] mem [0:255];

    // Memory model: answers a pending request rd_latency cycles after it appears.
    initial begin
        int cnt;
        cnt = 0;
        bus.mem_read_ready = 1'b0;
        bus.mem_write_ready = 1'b0;
        bus.mem_read_data = '0;
        forever begin
            @(negedge clk);
            bus.mem_read_ready = 1'b0;
            bus.mem_write_ready = 1'b0;
            if (!mem_on || !(bus.mem_read_valid || bus.mem_write_valid)) begin
                cnt = 0;
            end else if (cnt < rd_latency) begin
                cnt++;
            end else begin
                cnt = 0;
                if (bus.mem_read_valid) begin
                    bus.mem_read_ready = 1'b1;
                    bus.mem_read_data = mem[bus.mem_read_address];
                end else begin
                    bus.mem_write_ready = 1'b1;
                    mem[bus.mem_write_address] = bus.mem_write_data;
                end
            end
        end
    end

    // Consumers: drop valid once their ready is seen, logging the order served.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_release) begin
                for (int k = 0; k < N; k++) begin
                    if (bus.consumer_read_ready[k] && bus.consumer_read_valid[k]) begin
                        log_q.push_back(k);
                        $display("txn: consumer %0d read  addr %h data %h", k,
                                 bus.consumer_read_address[k], bus.consumer_read_data[k]);
                        bus.consumer_read_valid[k] = 1'b0;
                    end
                    if (bus.consumer_write_ready[k] && bus.consumer_write_valid[k]) begin
                        log_q.push_back(16 + k);
                        $display("txn: consumer %0d write addr %h data %h", k,
                                 bus.consumer_write_address[k], bus.consumer_write_data[k]);
                        bus.consumer_write_valid[k] = 1'b0;
                    end
                end
            end
        end
    end

    // Continuous structural checks, summarised by test_invariants.
    initial begin
        logic [N-1:0] rdy, own;
        forever begin
            @(negedge clk);
            rdy = bus.consumer_read_ready | bus.consumer_write_ready;
            own = '0;
            own[grant_id] = 1'b1;
            if ((rdy & ~own) != '0 || (bus.mem_read_valid && bus.mem_write_valid)) viol++;
            if (bus.mem_read_valid && !prev_rv) rd_starts++;
            prev_rv = bus.mem_read_valid;
            if (bus2.mem_write_valid || bus2.consumer_write_ready != '0) wr2_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (grant_id !== 2'd0) $display("FAIL reset_grant: got %0d want 0", grant_id); else passed++;
        total++; if ({bus.mem_read_valid, bus.mem_write_valid} !== 2'b00)
            $display("FAIL reset_mem_valid: got %b want 00", {bus.mem_read_valid, bus.mem_write_valid}); else passed++;
        total++; if ({bus.consumer_read_ready, bus.consumer_write_ready} !== 8'h00)
            $display("FAIL reset_ready: got %h want 00", {bus.consumer_read_ready, bus.consumer_write_ready}); else passed++;
        total++; if (bus.consumer_read_data !== '0) $display("FAIL reset_rdata: got %h want 0", bus.consumer_read_data); else passed++;
        total++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b want 0", timeout_err); else passed++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        auto_release = 1'b0;
        rd_latency = 3;
        mem[8'h10] = 16'hBEEF;
        bus.consumer_read_address[2] = 8'h10;
        bus.consumer_read_valid[2] = 1'b1;
        @(negedge clk);
        total++; if (grant_id !== 2'd2) $display("FAIL sr_grant: got %0d want 2", grant_id); else passed++;
        total++; if (bus.mem_read_valid !== 1'b1 || bus.mem_read_address !== 8'h10)
            $display("FAIL sr_mem_req: got valid %b addr %h want 1 10", bus.mem_read_valid, bus.mem_read_address); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL sr_busy: got %b want 1", busy); else passed++;
        for (int i = 0; i < 20 && bus.consumer_read_ready[2] !== 1'b1; i++) @(negedge clk);
        total++; if (bus.consumer_read_ready !== 4'b0100) $display("FAIL sr_ready: got %b want 0100", bus.consumer_read_ready); else passed++;
        total++; if (bus.consumer_read_data[2] !== 16'hBEEF) $display("FAIL sr_data: got %h want beef", bus.consumer_read_data[2]); else passed++;
        $display("txn: consumer 2 read  addr 10 data %h", bus.consumer_read_data[2]);
        @(negedge clk);
        total++; if (bus.consumer_read_ready !== 4'b0100) $display("FAIL sr_ready_hold: got %b want 0100", bus.consumer_read_ready); else passed++;
        bus.consumer_read_valid[2] = 1'b0;
        @(negedge clk);
        total++; if (bus.consumer_read_ready !== 4'b0000 || busy !== 1'b0)
            $display("FAIL sr_release: got ready %b busy %b want 0000 0", bus.consumer_read_ready, busy); else passed++;
        total++; if (bus.consumer_read_data[2] !== 16'hBEEF) $display("FAIL sr_data_hold: got %h want beef", bus.consumer_read_data[2]); else passed++;
    endtask

    task automatic test_all_read();
        do_reset();
        auto_release = 1'b1;
        rd_latency = 1;
        log_q.delete();
        rd_starts = 0;
        for (int k = 0; k < N; k++) begin
            bus.consumer_read_address[k] = AB'(32'h20 + k);
            mem[32'h20 + k] = DB'(32'hA000 + k);
        end
        bus.consumer_read_valid = 4'hF;
        for (int i = 0; i < 100 && bus.consumer_read_valid != '0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        total++; if (bus.consumer_read_valid !== 4'h0) $display("FAIL ar_done: got valid %b want 0000", bus.consumer_read_valid); else passed++;
        total++; if (log_q.size() != 4) $display("FAIL ar_count: got %0d want 4", log_q.size()); else passed++;
        for (int k = 0; k < N; k++) begin
            int got;
            got = (k < log_q.size()) ? log_q[k] : -1;
            total++; if (got != k) $display("FAIL ar_order%0d: got %0d want %0d", k, got, k); else passed++;
            total++; if (bus.consumer_read_data[k] !== DB'(32'hA000 + k))
                $display("FAIL ar_data%0d: got %h want %h", k, bus.consumer_read_data[k], DB'(32'hA000 + k)); else passed++;
        end
        total++; if (rd_starts != 4) $display("FAIL ar_mem_reqs: got %0d want 4", rd_starts); else passed++;
    endtask

    task automatic test_read_write();
        int first, second;
        auto_release = 1'b1;
        log_q.delete();
        mem[8'h30] = 16'h1111;
        mem[8'h31] = 16'h0000;
        bus.consumer_read_address[1] = 8'h30;
        bus.consumer_write_address[1] = 8'h31;
        bus.consumer_write_data[1] = 16'h5A5A;
        bus.consumer_read_valid[1] = 1'b1;
        bus.consumer_write_valid[1] = 1'b1;
        for (int i = 0; i < 100 && (bus.consumer_read_valid[1] || bus.consumer_write_valid[1]); i++) @(negedge clk);
        repeat (2) @(negedge clk);
        first = (log_q.size() > 0) ? log_q[0] : -1;
        second = (log_q.size() > 1) ? log_q[1] : -1;
        total++; if (first != 1) $display("FAIL rw_first: got %0d want 1 (read c1)", first); else passed++;
        total++; if (second != 17) $display("FAIL rw_second: got %0d want 17 (write c1)", second); else passed++;
        total++; if (mem[8'h31] !== 16'h5A5A) $display("FAIL rw_mem: got %h want 5a5a", mem[8'h31]); else passed++;
        total++; if (bus.consumer_read_data[1] !== 16'h1111) $display("FAIL rw_rdata: got %h want 1111", bus.consumer_read_data[1]); else passed++;
    endtask

    task automatic test_write_disabled();
        bus2.consumer_read_address[1] = 8'h40;
        bus2.consumer_write_address[1] = 8'h41;
        bus2.consumer_write_data[1] = 16'h7777;
        bus2.consumer_read_valid[1] = 1'b1;
        bus2.consumer_write_valid[1] = 1'b1;
        for (int i = 0; i < 20 && !bus2.mem_read_valid; i++) @(negedge clk);
        total++; if (bus2.mem_read_valid !== 1'b1 || grant_id2 !== 2'd1)
            $display("FAIL wd_grant: got valid %b id %0d want 1 1", bus2.mem_read_valid, grant_id2); else passed++;
        bus2.mem_read_data = 16'h0D0D;
        bus2.mem_read_ready = 1'b1;
        @(negedge clk);
        bus2.mem_read_ready = 1'b0;
        total++; if (bus2.consumer_read_ready !== 4'b0010 || bus2.consumer_read_data[1] !== 16'h0D0D)
            $display("FAIL wd_read: got ready %b data %h want 0010 0d0d", bus2.consumer_read_ready, bus2.consumer_read_data[1]); else passed++;
        $display("txn: ro-instance consumer 1 read  addr 40 data %h", bus2.consumer_read_data[1]);
        bus2.consumer_read_valid[1] = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (busy2 !== 1'b0) $display("FAIL wd_idle: got busy %b want 0", busy2); else passed++;
        total++; if (wr2_seen != 0) $display("FAIL wd_no_write: got %0d write cycles want 0", wr2_seen); else passed++;
        bus2.consumer_write_valid[1] = 1'b0;
    endtask

    task automatic test_write();
        auto_release = 1'b0;
        rd_latency = 1;
        mem[8'h7F] = 16'h0000;
        bus.consumer_write_address[3] = 8'h7F;
        bus.consumer_write_data[3] = 16'h1234;
        bus.consumer_write_valid[3] = 1'b1;
        @(negedge clk);
        total++; if (grant_id !== 2'd3) $display("FAIL wr_grant: got %0d want 3", grant_id); else passed++;
        total++; if (bus.mem_write_valid !== 1'b1 || bus.mem_read_valid !== 1'b0)
            $display("FAIL wr_valids: got wv %b rv %b want 1 0", bus.mem_write_valid, bus.mem_read_valid); else passed++;
        total++; if (bus.mem_write_address !== 8'h7F || bus.mem_write_data !== 16'h1234)
            $display("FAIL wr_payload: got %h %h want 7f 1234", bus.mem_write_address, bus.mem_write_data); else passed++;
        for (int i = 0; i < 20 && bus.consumer_write_ready[3] !== 1'b1; i++) @(negedge clk);
        total++; if (bus.consumer_write_ready !== 4'b1000) $display("FAIL wr_ack: got %b want 1000", bus.consumer_write_ready); else passed++;
        $display("txn: consumer 3 write addr 7f data 1234");
        bus.consumer_write_valid[3] = 1'b0;
        @(negedge clk);
        total++; if (bus.consumer_write_ready !== 4'b0000 || busy !== 1'b0)
            $display("FAIL wr_release: got ready %b busy %b want 0000 0", bus.consumer_write_ready, busy); else passed++;
        total++; if (mem[8'h7F] !== 16'h1234) $display("FAIL wr_mem: got %h want 1234", mem[8'h7F]); else passed++;
    endtask

    task automatic test_reset_mid();
        int first, second;
        mem_on = 1'b0;
        auto_release = 1'b0;
        bus.consumer_read_address[2] = 8'h10;
        bus.consumer_read_valid[2] = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b1 || bus.mem_read_valid !== 1'b1)
            $display("FAIL rm_waiting: got busy %b rv %b want 1 1", busy, bus.mem_read_valid); else passed++;
        #2 reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || bus.mem_read_valid !== 1'b0 || grant_id !== 2'd0)
            $display("FAIL rm_async_clear: got busy %b rv %b id %0d want 0 0 0", busy, bus.mem_read_valid, grant_id); else passed++;
        total++; if (bus.consumer_read_data !== '0 || bus.consumer_read_ready !== 4'b0000)
            $display("FAIL rm_async_outputs: got data %h ready %b want 0 0000", bus.consumer_read_data, bus.consumer_read_ready); else passed++;
        bus.consumer_read_valid[2] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mem_on = 1'b1;
        auto_release = 1'b1;
        log_q.delete();
        bus.consumer_read_valid[0] = 1'b1;
        bus.consumer_read_valid[3] = 1'b1;
        for (int i = 0; i < 100 && bus.consumer_read_valid != '0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        first = (log_q.size() > 0) ? log_q[0] : -1;
        second = (log_q.size() > 1) ? log_q[1] : -1;
        total++; if (first != 0 || second != 3)
            $display("FAIL rm_priority: got order %0d,%0d want 0,3", first, second); else passed++;
    endtask

    task automatic test_timeout();
        int cnt;
        mem_on = 1'b0;
        auto_release = 1'b0;
        bus.consumer_read_valid[0] = 1'b1;
        @(negedge clk);
`ifdef MEM_ARB_TIMEOUT_EN
        cnt = 0;
        while (bus.consumer_read_ready[0] !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        total++; if (cnt != 8) $display("FAIL to_cycles: got %0d want 8", cnt); else passed++;
        total++; if (bus.consumer_read_data[0] !== 16'h0000 || bus.mem_read_valid !== 1'b0)
            $display("FAIL to_data: got data %h rv %b want 0000 0", bus.consumer_read_data[0], bus.mem_read_valid); else passed++;
        total++; if (timeout_err !== 1'b1) $display("FAIL to_flag: got %b want 1", timeout_err); else passed++;
        $display("txn: consumer 0 read  timed out data %h", bus.consumer_read_data[0]);
        bus.consumer_read_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (timeout_err !== 1'b1 || busy !== 1'b0)
            $display("FAIL to_sticky: got err %b busy %b want 1 0", timeout_err, busy); else passed++;
        mem_on = 1'b1;
`else
        repeat (20) @(negedge clk);
        total++; if (bus.consumer_read_ready !== 4'b0000 || busy !== 1'b1)
            $display("FAIL nto_wait: got ready %b busy %b want 0000 1", bus.consumer_read_ready, busy); else passed++;
        total++; if (timeout_err !== 1'b0) $display("FAIL nto_flag: got %b want 0", timeout_err); else passed++;
        mem_on = 1'b1;
        cnt = 0;
        while (bus.consumer_read_ready[0] !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        total++; if (bus.consumer_read_ready !== 4'b0001 || bus.consumer_read_data[0] !== 16'hA000)
            $display("FAIL nto_complete: got ready %b data %h want 0001 a000", bus.consumer_read_ready, bus.consumer_read_data[0]); else passed++;
        $display("txn: consumer 0 read  addr 20 data %h", bus.consumer_read_data[0]);
        bus.consumer_read_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
`endif
    endtask

    task automatic test_invariants();
        total++; if (viol != 0) $display("FAIL invariants: got %0d violating cycles want 0", viol); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = DB'(i);
        bus.consumer_read_valid = '0;
        bus.consumer_read_address = '0;
        bus.consumer_write_valid = '0;
        bus.consumer_write_address = '0;
        bus.consumer_write_data = '0;
        bus2.consumer_read_valid = '0;
        bus2.consumer_read_address = '0;
        bus2.consumer_write_valid = '0;
        bus2.consumer_write_address = '0;
        bus2.consumer_write_data = '0;
        bus2.mem_read_ready = 1'b0;
        bus2.mem_read_data = '0;
        bus2.mem_write_ready = 1'b0;
        reset = 1'b0;

        test_reset();
        test_single_read();
        test_all_read();
        test_read_write();
        test_write_disabled();
        test_write();
        test_reset_mid();
        test_timeout();
        test_invariants();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
